// File: rtl/defs_pkg.sv
// Shared AXI definitions and the read-arbiter state encoding.
package defs_pkg;
  localparam int AxiIdWidth = 4;

  typedef enum logic [1:0] {
    BURST_FIXED = 2'b00,
    BURST_INCR  = 2'b01,
    BURST_WRAP  = 2'b10
  } axi_burst_t;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    ADDR = 2'b01,
    DATA = 2'b10
  } arb_state_t;
endpackage

// File: rtl/axi_rd_arbiter_rr_arb2.sv
// Two-way round-robin picker; the pointer names the requester favoured on a tie.
module rr_arb2 (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req,
  input  logic       update,
  input  logic       owner,
  output logic [1:0] gnt
);
  logic ptr_reg;

  // After a burst, favour whichever requester did not own it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_reg <= 1'b0;
    end else if (update) begin
      ptr_reg <= ~owner;
    end
  end

  always_comb begin
    gnt = req;
    if (req == 2'b11) begin
      gnt = ptr_reg ? 2'b10 : 2'b01;
    end
  end
endmodule

// File: rtl/axi_rd_arbiter.sv
// Two-requester AXI4 read arbiter: one burst at a time, R beats steered to the owner,
// flushed bursts drained downstream, burst-length violations flagged.
module axi_rd_arbiter
  import defs_pkg::*;
#(
  parameter int AddrWidth = 32,
  parameter int DataWidth = 64,
  parameter int IdWidth   = AxiIdWidth
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [1:0]                    m_arvalid,
  output logic [1:0]                    m_arready,
  input  logic [1:0][AddrWidth-1:0]     m_araddr,
  input  logic [1:0][7:0]               m_arlen,
  input  logic [1:0][2:0]               m_arsize,
  input  logic [1:0][1:0]               m_arburst,
  input  logic [1:0][IdWidth-1:0]       m_arid,
  input  logic [1:0]                    m_flush,
  output logic [1:0]                    m_rvalid,
  input  logic [1:0]                    m_rready,
  output logic [DataWidth-1:0]          m_rdata,
  output logic [1:0]                    m_rresp,
  output logic                          m_rlast,
  output logic [IdWidth-1:0]            m_rid,
  output logic                          s_arvalid,
  input  logic                          s_arready,
  output logic [AddrWidth-1:0]          s_araddr,
  output logic [7:0]                    s_arlen,
  output logic [2:0]                    s_arsize,
  output logic [1:0]                    s_arburst,
  output logic [IdWidth-1:0]            s_arid,
  input  logic                          s_rvalid,
  output logic                          s_rready,
  input  logic [DataWidth-1:0]          s_rdata,
  input  logic [1:0]                    s_rresp,
  input  logic                          s_rlast,
  input  logic [IdWidth-1:0]            s_rid,
  output logic                          gnt_id,
  output logic                          busy,
  output logic                          len_err
);
  arb_state_t           state_reg, state_next;
  logic                 gnt_id_reg;
  logic [AddrWidth-1:0] addr_reg;
  logic [7:0]           len_reg;
  logic [2:0]           size_reg;
  logic [1:0]           burst_reg;
  logic [IdWidth-1:0]   id_reg;
  logic [8:0]           beat_cnt_reg;
  logic                 drain_reg;

  logic [1:0] gnt;
  logic       winner;
  logic       grant_fire;
  logic       drain_now;
  logic       r_fire;
  logic       burst_end;

  assign winner     = gnt[1];
  assign grant_fire = (state_reg == IDLE) && (|m_arvalid);
  // A flush arriving with a beat suppresses that beat too, not just later ones.
  assign drain_now  = drain_reg | m_flush[gnt_id_reg];
  assign burst_end  = r_fire & s_rlast;

  rr_arb2 u_rr (
    .clk    (clk),
    .rst_n  (rst_n),
    .req    (m_arvalid),
    .update (burst_end),
    .owner  (gnt_id_reg),
    .gnt    (gnt)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    m_arready  = 2'b00;
    s_arvalid  = 1'b0;
    s_rready   = 1'b0;
    m_rvalid   = 2'b00;
    r_fire     = 1'b0;
    len_err    = 1'b0;
    case (state_reg)
      IDLE: begin
        m_arready = gnt;
        if (|m_arvalid) state_next = ADDR;
      end
      ADDR: begin
        s_arvalid = 1'b1;
        if (s_arready) state_next = DATA;
      end
      DATA: begin
        s_rready             = drain_now | m_rready[gnt_id_reg];
        m_rvalid[gnt_id_reg] = s_rvalid & ~drain_now;
        r_fire               = s_rvalid & s_rready;
        len_err = r_fire & ((s_rlast & (beat_cnt_reg != {1'b0, len_reg})) |
                            (~s_rlast & (beat_cnt_reg == {1'b0, len_reg})));
        if (r_fire && s_rlast) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gnt_id_reg   <= 1'b0;
      addr_reg     <= '0;
      len_reg      <= '0;
      size_reg     <= '0;
      burst_reg    <= '0;
      id_reg       <= '0;
      beat_cnt_reg <= '0;
      drain_reg    <= 1'b0;
    end else if (grant_fire) begin
      gnt_id_reg   <= winner;
      addr_reg     <= m_araddr[winner];
      len_reg      <= m_arlen[winner];
      size_reg     <= m_arsize[winner];
      burst_reg    <= m_arburst[winner];
      id_reg       <= m_arid[winner];
      beat_cnt_reg <= '0;
      drain_reg    <= m_flush[winner];
    end else if (state_reg != IDLE) begin
      if (m_flush[gnt_id_reg]) drain_reg <= 1'b1;
      if (r_fire) beat_cnt_reg <= beat_cnt_reg + 9'd1;
    end
  end

  assign s_araddr  = addr_reg;
  assign s_arlen   = len_reg;
  assign s_arsize  = size_reg;
  assign s_arburst = burst_reg;
  assign s_arid    = id_reg;
  assign m_rdata   = s_rdata;
  assign m_rresp   = s_rresp;
  assign m_rlast   = s_rlast;
  assign m_rid     = s_rid;
  assign gnt_id    = gnt_id_reg;
  assign busy      = (state_reg != IDLE);
endmodule

// File: tb/tb_axi_rd_arbiter.sv
// Directed self-checking bench for axi_rd_arbiter: one task per scenario.
module tb_axi_rd_arbiter;
  import defs_pkg::*;

  localparam int AW = 32;
  localparam int DW = 64;
  localparam int IW = AxiIdWidth;

  logic                   clk = 1'b0;
  logic                   rst_n;
  logic [1:0]             m_arvalid;
  logic [1:0]             m_arready;
  logic [1:0][AW-1:0]     m_araddr;
  logic [1:0][7:0]        m_arlen;
  logic [1:0][2:0]        m_arsize;
  logic [1:0][1:0]        m_arburst;
  logic [1:0][IW-1:0]     m_arid;
  logic [1:0]             m_flush;
  logic [1:0]             m_rvalid;
  logic [1:0]             m_rready;
  logic [DW-1:0]          m_rdata;
  logic [1:0]             m_rresp;
  logic                   m_rlast;
  logic [IW-1:0]          m_rid;
  logic                   s_arvalid;
  logic                   s_arready;
  logic [AW-1:0]          s_araddr;
  logic [7:0]             s_arlen;
  logic [2:0]             s_arsize;
  logic [1:0]             s_arburst;
  logic [IW-1:0]          s_arid;
  logic                   s_rvalid;
  logic                   s_rready;
  logic [DW-1:0]          s_rdata;
  logic [1:0]             s_rresp;
  logic                   s_rlast;
  logic [IW-1:0]          s_rid;
  logic                   gnt_id;
  logic                   busy;
  logic                   len_err;

  int n_cmp = 0;
  int n_err = 0;

  axi_rd_arbiter #(.AddrWidth(AW), .DataWidth(DW), .IdWidth(IW)) dut (
    .clk(clk), .rst_n(rst_n),
    .m_arvalid(m_arvalid), .m_arready(m_arready), .m_araddr(m_araddr),
    .m_arlen(m_arlen), .m_arsize(m_arsize), .m_arburst(m_arburst), .m_arid(m_arid),
    .m_flush(m_flush), .m_rvalid(m_rvalid), .m_rready(m_rready),
    .m_rdata(m_rdata), .m_rresp(m_rresp), .m_rlast(m_rlast), .m_rid(m_rid),
    .s_arvalid(s_arvalid), .s_arready(s_arready), .s_araddr(s_araddr),
    .s_arlen(s_arlen), .s_arsize(s_arsize), .s_arburst(s_arburst), .s_arid(s_arid),
    .s_rvalid(s_rvalid), .s_rready(s_rready), .s_rdata(s_rdata),
    .s_rresp(s_rresp), .s_rlast(s_rlast), .s_rid(s_rid),
    .gnt_id(gnt_id), .busy(busy), .len_err(len_err)
  );

  always #5 clk = ~clk;

  // Advance to 1 time unit after the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int r, input logic [AW-1:0] addr, input logic [7:0] len);
    m_araddr[r]  = addr;
    m_arlen[r]   = len;
    m_arsize[r]  = 3'd3;
    m_arburst[r] = BURST_INCR;
    m_arid[r]    = IW'(r + 2);
  endtask

  task automatic clear_inputs();
    m_arvalid = 2'b00; m_araddr = '0; m_arlen = '0; m_arsize = '0;
    m_arburst = '0; m_arid = '0; m_flush = 2'b00; m_rready = 2'b11;
    s_arready = 1'b0; s_rvalid = 1'b0; s_rdata = '0; s_rresp = 2'b00;
    s_rlast = 1'b0; s_rid = '0;
  endtask

  task automatic apply_reset();
    clear_inputs();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    clear_inputs();
    rst_n = 1'b0;
    #1;
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b want 0", busy); end
    n_cmp++; if (s_arvalid !== 1'b0) begin n_err++; $display("FAIL reset_s_arvalid: got %b want 0", s_arvalid); end
    n_cmp++; if (m_arready !== 2'b00) begin n_err++; $display("FAIL reset_m_arready: got %b want 00", m_arready); end
    n_cmp++; if (s_rready !== 1'b0) begin n_err++; $display("FAIL reset_s_rready: got %b want 0", s_rready); end
    n_cmp++; if (gnt_id !== 1'b0) begin n_err++; $display("FAIL reset_gnt_id: got %b want 0", gnt_id); end
    n_cmp++; if (s_araddr !== 32'h0) begin n_err++; $display("FAIL reset_s_araddr: got %h want 0", s_araddr); end
    step();
    rst_n = 1'b1;
    $display("test_reset done");
  endtask

  task automatic test_single_fetch();
    set_req(0, 32'h0000_1000, 8'd3);
    m_arvalid = 2'b01;
    #1;
    n_cmp++; if (m_arready !== 2'b01) begin n_err++; $display("FAIL fetch_arready: got %b want 01", m_arready); end
    step();
    m_arvalid = 2'b00;
    #1;
    n_cmp++; if (s_arvalid !== 1'b1) begin n_err++; $display("FAIL fetch_s_arvalid: got %b want 1", s_arvalid); end
    n_cmp++; if (s_araddr !== 32'h0000_1000) begin n_err++; $display("FAIL fetch_s_araddr: got %h want 00001000", s_araddr); end
    n_cmp++; if (s_arlen !== 8'd3) begin n_err++; $display("FAIL fetch_s_arlen: got %0d want 3", s_arlen); end
    n_cmp++; if (s_arid !== IW'(2)) begin n_err++; $display("FAIL fetch_s_arid: got %0d want 2", s_arid); end
    n_cmp++; if (busy !== 1'b1) begin n_err++; $display("FAIL fetch_busy: got %b want 1", busy); end
    step();
    n_cmp++; if (s_arvalid !== 1'b1) begin n_err++; $display("FAIL fetch_ar_hold: got %b want 1", s_arvalid); end
    s_arready = 1'b1;
    step();
    s_arready = 1'b0;
    for (int b = 0; b < 4; b++) begin
      s_rvalid = 1'b1; s_rdata = 64'hA0 + 64'(b); s_rlast = (b == 3);
      #1;
      n_cmp++; if (m_rvalid !== 2'b01) begin n_err++; $display("FAIL fetch_m_rvalid b%0d: got %b want 01", b, m_rvalid); end
      n_cmp++; if (m_rdata !== 64'hA0 + 64'(b)) begin n_err++; $display("FAIL fetch_m_rdata b%0d: got %h want %h", b, m_rdata, 64'hA0 + 64'(b)); end
      n_cmp++; if (len_err !== 1'b0) begin n_err++; $display("FAIL fetch_len_err b%0d: got %b want 0", b, len_err); end
      step();
    end
    s_rvalid = 1'b0; s_rlast = 1'b0;
    #1;
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL fetch_busy_end: got %b want 0", busy); end
    $display("test_single_fetch done");
  endtask

  task automatic test_contention();
    logic [1:0] want;
    apply_reset();
    set_req(0, 32'h0000_0100, 8'd0);
    set_req(1, 32'h0000_0200, 8'd0);
    m_arvalid = 2'b11;
    for (int k = 0; k < 4; k++) begin
      want = (k % 2 == 0) ? 2'b01 : 2'b10;
      #1;
      n_cmp++; if (m_arready !== want) begin n_err++; $display("FAIL contend_arready g%0d: got %b want %b", k, m_arready, want); end
      step();
      s_arready = 1'b1;
      #1;
      n_cmp++; if (gnt_id !== want[1]) begin n_err++; $display("FAIL contend_gnt_id g%0d: got %b want %b", k, gnt_id, want[1]); end
      n_cmp++; if (m_arready !== 2'b00) begin n_err++; $display("FAIL contend_arready_addr g%0d: got %b want 00", k, m_arready); end
      step();
      s_arready = 1'b0; s_rvalid = 1'b1; s_rlast = 1'b1;
      #1;
      n_cmp++; if (m_rvalid !== want) begin n_err++; $display("FAIL contend_m_rvalid g%0d: got %b want %b", k, m_rvalid, want); end
      step();
      s_rvalid = 1'b0; s_rlast = 1'b0;
      $display("contention grant %0d to requester %0d", k, want[1]);
    end
    m_arvalid = 2'b00;
  endtask

  task automatic test_backpressure();
    int beats;
    apply_reset();
    set_req(0, 32'h0000_4000, 8'd3);
    m_arvalid = 2'b01;
    step();
    m_arvalid = 2'b00; s_arready = 1'b1;
    step();
    s_arready = 1'b0;
    beats = 0;
    for (int c = 0; c < 7; c++) begin
      m_rready = (c >= 1 && c <= 3) ? 2'b10 : 2'b11;
      s_rvalid = 1'b1; s_rdata = 64'hB0 + 64'(beats); s_rlast = (beats == 3);
      #1;
      if (c >= 1 && c <= 3) begin
        n_cmp++; if (s_rready !== 1'b0) begin n_err++; $display("FAIL bp_s_rready c%0d: got %b want 0", c, s_rready); end
      end
      n_cmp++; if (m_rdata !== 64'hB0 + 64'(beats)) begin n_err++; $display("FAIL bp_m_rdata c%0d: got %h want %h", c, m_rdata, 64'hB0 + 64'(beats)); end
      if (s_rready === 1'b1) beats++;
      step();
    end
    s_rvalid = 1'b0; s_rlast = 1'b0; m_rready = 2'b11;
    #1;
    n_cmp++; if (beats != 4) begin n_err++; $display("FAIL bp_beats: got %0d want 4", beats); end
    n_cmp++; if (dut.beat_cnt_reg !== 9'd4) begin n_err++; $display("FAIL bp_beat_cnt: got %0d want 4", dut.beat_cnt_reg); end
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL bp_busy_end: got %b want 0", busy); end
    $display("test_backpressure done");
  endtask

  task automatic test_flush();
    apply_reset();
    set_req(0, 32'h0000_5000, 8'd7);
    set_req(1, 32'h0000_2000, 8'd0);
    m_arvalid = 2'b11;
    #1;
    n_cmp++; if (m_arready !== 2'b01) begin n_err++; $display("FAIL flush_arready0: got %b want 01", m_arready); end
    step();
    m_arvalid = 2'b10; s_arready = 1'b1;
    step();
    s_arready = 1'b0; m_rready = 2'b01;
    for (int b = 0; b < 2; b++) begin
      s_rvalid = 1'b1; s_rlast = 1'b0;
      #1;
      n_cmp++; if (m_rvalid !== 2'b01) begin n_err++; $display("FAIL flush_pre_rvalid b%0d: got %b want 01", b, m_rvalid); end
      step();
    end
    s_rvalid = 1'b0; m_flush = 2'b01;
    step();
    m_flush = 2'b00; m_rready = 2'b00;
    for (int b = 2; b < 8; b++) begin
      s_rvalid = 1'b1; s_rlast = (b == 7);
      #1;
      n_cmp++; if (s_rready !== 1'b1) begin n_err++; $display("FAIL flush_s_rready b%0d: got %b want 1", b, s_rready); end
      n_cmp++; if (m_rvalid !== 2'b00) begin n_err++; $display("FAIL flush_m_rvalid b%0d: got %b want 00", b, m_rvalid); end
      step();
    end
    s_rvalid = 1'b0; s_rlast = 1'b0;
    #1;
    n_cmp++; if (m_arready !== 2'b10) begin n_err++; $display("FAIL flush_next_arready: got %b want 10", m_arready); end
    step();
    m_arvalid = 2'b00;
    #1;
    n_cmp++; if (s_arvalid !== 1'b1) begin n_err++; $display("FAIL flush_next_s_arvalid: got %b want 1", s_arvalid); end
    n_cmp++; if (gnt_id !== 1'b1) begin n_err++; $display("FAIL flush_next_gnt_id: got %b want 1", gnt_id); end
    n_cmp++; if (s_araddr !== 32'h0000_2000) begin n_err++; $display("FAIL flush_next_addr: got %h want 00002000", s_araddr); end
    s_arready = 1'b1;
    step();
    s_arready = 1'b0; m_rready = 2'b11; s_rvalid = 1'b1; s_rlast = 1'b1;
    #1;
    n_cmp++; if (m_rvalid !== 2'b10) begin n_err++; $display("FAIL flush_r1_rvalid: got %b want 10", m_rvalid); end
    step();
    s_rvalid = 1'b0; s_rlast = 1'b0;
    $display("test_flush done");
  endtask

  task automatic test_len_error();
    logic want;
    set_req(0, 32'h0000_6000, 8'd3);
    m_arvalid = 2'b01;
    step();
    m_arvalid = 2'b00; s_arready = 1'b1;
    step();
    s_arready = 1'b0;
    for (int b = 0; b < 3; b++) begin
      want = (b == 2);
      s_rvalid = 1'b1; s_rlast = (b == 2);
      #1;
      n_cmp++; if (len_err !== want) begin n_err++; $display("FAIL lenerr_early b%0d: got %b want %b", b, len_err, want); end
      step();
    end
    s_rvalid = 1'b0; s_rlast = 1'b0;
    #1;
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL lenerr_early_idle: got %b want 0", busy); end
    set_req(0, 32'h0000_6100, 8'd0);
    m_arvalid = 2'b01;
    step();
    m_arvalid = 2'b00; s_arready = 1'b1;
    step();
    s_arready = 1'b0;
    for (int b = 0; b < 2; b++) begin
      s_rvalid = 1'b1; s_rlast = (b == 1);
      #1;
      n_cmp++; if (len_err !== 1'b1) begin n_err++; $display("FAIL lenerr_late b%0d: got %b want 1", b, len_err); end
      step();
    end
    s_rvalid = 1'b0; s_rlast = 1'b0;
    #1;
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL lenerr_late_idle: got %b want 0", busy); end
    $display("test_len_error done");
  endtask

  task automatic test_async_reset();
    set_req(1, 32'h0000_7000, 8'd3);
    m_arvalid = 2'b10;
    step();
    m_arvalid = 2'b00; s_arready = 1'b1;
    step();
    s_arready = 1'b0; s_rvalid = 1'b1; s_rlast = 1'b0;
    #1;
    n_cmp++; if (m_rvalid !== 2'b10) begin n_err++; $display("FAIL arst_pre_rvalid: got %b want 10", m_rvalid); end
    step();
    rst_n = 1'b0;
    #1;
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL arst_busy: got %b want 0", busy); end
    n_cmp++; if (m_rvalid !== 2'b00) begin n_err++; $display("FAIL arst_m_rvalid: got %b want 00", m_rvalid); end
    n_cmp++; if (s_rready !== 1'b0) begin n_err++; $display("FAIL arst_s_rready: got %b want 0", s_rready); end
    n_cmp++; if (gnt_id !== 1'b0) begin n_err++; $display("FAIL arst_gnt_id: got %b want 0", gnt_id); end
    n_cmp++; if (m_arready !== 2'b00) begin n_err++; $display("FAIL arst_m_arready: got %b want 00", m_arready); end
    s_rvalid = 1'b0;
    step();
    rst_n = 1'b1;
    set_req(0, 32'h0000_3000, 8'd0);
    m_arvalid = 2'b11;
    #1;
    n_cmp++; if (m_arready !== 2'b01) begin n_err++; $display("FAIL arst_fresh_arready: got %b want 01", m_arready); end
    step();
    m_arvalid = 2'b00;
    #1;
    n_cmp++; if (s_arvalid !== 1'b1) begin n_err++; $display("FAIL arst_fresh_s_arvalid: got %b want 1", s_arvalid); end
    n_cmp++; if (s_araddr !== 32'h0000_3000) begin n_err++; $display("FAIL arst_fresh_addr: got %h want 00003000", s_araddr); end
    $display("test_async_reset done");
  endtask

  initial begin
    test_reset();
    test_single_fetch();
    test_contention();
    test_backpressure();
    test_flush();
    test_len_error();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/axi_rd_arbiter.md
# axi_rd_arbiter

Two-requester AXI4 read-channel arbiter that shares one downstream AR/R port between the instruction-fetch memory controller (requester 0) and the load/store unit (requester 1). It grants one burst at a time round-robin, forwards the latched AR beat downstream, and steers R beats back to the owner. It also drains bursts whose owner has flushed and flags burst-length violations.

## Interface
- `AddrWidth`, 32, AR address width
- `DataWidth`, 64, R data width
- `IdWidth`, `AxiIdWidth` (defs_pkg), AR/R ID width
- `clk` in 1, clock
- `rst_n` in 1, reset: asynchronous, active-low
- `m_arvalid` in [1:0], per-requester AR valid
- `m_arready` out [1:0], per-requester AR accept
- `m_araddr` in [1:0][AddrWidth-1:0], request address
- `m_arlen` / `m_arsize` / `m_arburst` / `m_arid` in [1:0][8/3/2/IdWidth bits], burst attributes
- `m_flush` in [1:0], requester discards its in-flight burst
- `m_rvalid` out [1:0], R beat valid to requester
- `m_rready` in [1:0], requester R ready
- `m_rdata` / `m_rresp` / `m_rlast` / `m_rid` out [DataWidth/2/1/IdWidth], shared R payload to both requesters, qualified by `m_rvalid`
- `s_arvalid` out 1, `s_arready` in 1, `s_araddr`/`s_arlen`/`s_arsize`/`s_arburst`/`s_arid` out, downstream AR; other AR fields tie to 0
- `s_rvalid` in 1, `s_rready` out 1, `s_rdata`/`s_rresp`/`s_rlast`/`s_rid` in, downstream R
- `gnt_id` out 1, current owner
- `busy` out 1, state != IDLE
- `len_err` out 1, one-cycle pulse on burst-length violation

## Operation
- States: IDLE, ADDR, DATA.
- IDLE: when any `m_arvalid` is high, pick a winner. If both are high, the winner is the requester not granted last. The pointer resets to favour requester 0. Assert `m_arready[g]` combinationally in that cycle. At the clock edge, latch addr/len/size/burst/id and `gnt_id`, clear `beat_cnt`, clear `drain`, then go to ADDR.
- ADDR: `s_arvalid`=1 with the latched fields, held stable until `s_arready`. Then go to DATA.
- DATA: `s_rready` = `drain | m_rready[gnt_id]`. `m_rvalid[gnt_id]` = `s_rvalid & ~drain`; the other requester's `m_rvalid` is 0. Payload passes through combinationally. Each `s_rvalid&s_rready` increments the 9-bit `beat_cnt`.
- Burst end: a handshaken beat with `s_rlast` returns to IDLE and toggles the round-robin pointer to the other requester.
- Length check: pulse `len_err` if `s_rlast` arrives on a beat where `beat_cnt != arlen`, or if a beat arrives with `beat_cnt == arlen` and no `s_rlast`. In both cases the FSM still tracks `s_rlast` to end the burst.
- Flush: `m_flush[gnt_id]` in ADDR or DATA sets sticky `drain`. `m_flush` on the winner in its grant cycle also sets `drain`. Flush of the non-owner is ignored. The downstream burst always completes; the arbiter never aborts AXI.
- `m_rid` carries `s_rid` unchanged; the ID is not used for routing (single outstanding burst).

## Timing
- Reset: state IDLE, pointer 0, `s_arvalid`/`m_rvalid`/`m_arready`/`s_rready`/`len_err`/`busy`/`gnt_id` = 0, latched fields 0.
- Latency: `m_arvalid` (IDLE, cycle N) → `s_arvalid` at N+1. R path has zero latency.
- After the last beat, there is one IDLE cycle before the next grant; the next AR is earliest 2 cycles after `rlast`.
- Flush in the same cycle as the last beat: that beat is suppressed to the requester, and the FSM returns to IDLE normally.
- `s_rvalid` outside DATA is ignored, with `s_rready`=0.
- Reset mid-burst: asynchronous clear to IDLE. The downstream transaction is abandoned, since the system resets globally.

## Structure
- defs_pkg holds `AxiIdWidth` and the burst enum (INCR). Add `arb_state_t` (IDLE/ADDR/DATA, logic [1:0]) there for bench visibility.
- One sub-module, `rr_arb2`: a 2-way round-robin picker with req[1:0], an update strobe, and gnt outputs. The pointer register lives inside it.

## Test plan
- Single fetch: `m_arvalid`=2'b01, addr 0x1000, len 3 → `s_arvalid` next cycle with addr 0x1000, len 3; 4 beats reach requester 0 only; `len_err`=0; `busy` falls after `rlast`.
- Contention: both valid continuously, len 0 each → grants alternate 0,1,0,1; each `m_arready` pulses once per grant.
- Backpressure: `m_rready[0]` low for 3 cycles mid-burst → `s_rready`=0 for those cycles; no beat lost; `beat_cnt` ends at 4 for len 3.
- Flush: `m_flush[0]` pulses after beat 1 of an 8-beat burst (len 7) → beats 2..7 consumed with `s_rready`=1 and `m_rvalid`=0; a pending requester-1 request is granted 1 cycle after `rlast`.
- Length error: len 3, `s_rlast` on beat 2 → `len_err` pulses in that cycle; FSM returns to IDLE.
- Async reset asserted in DATA → all outputs 0 immediately; after release, a fresh request is served from IDLE with requester 0 favoured.
